// File: rtl/reg_bank_pkg.sv
// Shared constants for the register-bank arbiter: FSM encoding and default widths.
package reg_bank_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after prio_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   prio_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       idx_sum;
  logic                 any_req;

  // Rotate so bit 0 of req_rot is the requester at prio_ptr.
  assign req_dbl = {req, req} >> prio_ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    any_req   = 1'b0;
    idx_sum   = '0;
    grant_idx = '0;
    // Descending scan so the lowest rotated offset is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_req = 1'b1;
        idx_sum = {1'b0, prio_ptr} + (IDX_W + 1)'(k);
      end
    end
    if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
    end
    grant_idx = idx_sum[IDX_W-1:0];
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared register-bank controller: round-robin grants one read/write command at a
// time, executes it against a flop bank and returns a one-cycle response.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]        state_reg;
  logic [IDX_W-1:0]  prio_ptr_reg;
  logic [IDX_W-1:0]  gnt_idx_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] bank_reg [DEPTH];

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .prio_ptr  (prio_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Gated by rst so ready stays low while reset is held, even with valids up.
  assign req_ready = (state_reg == ST_IDLE && rst) ? arb_grant : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_rdata = (state_reg == ST_RESP) ? rdata_reg : '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_reg == ST_RESP) && (gnt_idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      prio_ptr_reg <= '0;
      gnt_idx_reg  <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt_idx_reg  <= arb_idx;
            we_reg       <= req_we[arb_idx];
            addr_reg     <= addr_arr[arb_idx];
            wdata_reg    <= wdata_arr[arb_idx];
            prio_ptr_reg <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            state_reg    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Writes echo their own data back as the response.
          if (we_reg) begin
            bank_reg[addr_reg] <= wdata_reg;
            rdata_reg          <= wdata_reg;
          end else begin
            rdata_reg <= bank_reg[addr_reg];
          end
          state_reg <= ST_RESP;
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a cycle model predicting ready/busy and a
// response scoreboard filled at each handshake and drained at each response.
module tb_reg_bank_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 3;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;

  reg_bank_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp;
  int            n_err;
  int            m_phase;
  int            m_ptr;
  logic [DW-1:0] m_bank [1<<AW];
  exp_t          sb [$];
  int            glog [$];
  int            gcyc [$];
  int            cyc;
  int            rsp_cyc;
  logic [DW-1:0] last_rdata;
  bit            keep [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    for (int i = 0; i < (1 << AW); i++) m_bank[i] = '0;
    sb.delete();
  endtask

  // One clock: check at the negedge, advance the model, return at posedge+1.
  task automatic tick();
    int          w;
    int          c;
    exp_t        e;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    cyc++;
    w = -1;
    exp_ready = '0;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
      if (w >= 0) exp_ready = N'(1 << w);
    end
    chk("ready", req_ready, exp_ready);
    chk("busy", busy, m_phase != 0);
    if (m_phase == 2) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 1 << e.idx);
      chk("rsp_rdata", rsp_rdata, e.data);
      last_rdata = rsp_rdata;
      rsp_cyc    = cyc;
    end else begin
      chk("rsp_valid_quiet", rsp_valid, 0);
      chk("rsp_rdata_quiet", rsp_rdata, 0);
    end
    case (m_phase)
      0: if (w >= 0) begin
        e.idx  = w;
        e.data = req_we[w] ? req_wdata[w*DW +: DW] : m_bank[req_addr[w*AW +: AW]];
        if (req_we[w]) m_bank[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
        sb.push_back(e);
        glog.push_back(w);
        gcyc.push_back(cyc);
        m_ptr   = (w + 1) % N;
        m_phase = 1;
      end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    if (w >= 0 && !keep[w]) req_valid[w] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int t;
    t = 0;
    while (glog.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk("grant_count", glog.size(), n);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (m_phase != 0 && t < 10) begin
      tick();
      t++;
    end
  endtask

  task automatic do_op(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n0;
    n0 = glog.size();
    set_req(i, we, a, d);
    wait_grants(n0 + 1, 20);
    drain();
  endtask

  initial begin
    int n0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rsp_cyc = 0;
    last_rdata = '0;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
    model_reset();
    rst       = 1'b0;
    req_valid = 4'b0010;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset: outputs quiet even with a valid present.
    #8;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    do_op(0, 1'b0, 3'd5, 8'h00);
    chk("rst_bank_read", last_rdata, 8'h00);

    // Single write then read-back.
    do_op(1, 1'b1, 3'd3, 8'hA5);
    chk("wr_latency", rsp_cyc - gcyc[$], 2);
    chk("wr_echo", last_rdata, 8'hA5);
    do_op(1, 1'b0, 3'd3, 8'h00);
    chk("rd_after_wr", last_rdata, 8'hA5);

    // Priority rotation after a grant to requester 2.
    do_op(2, 1'b0, 3'd3, 8'h00);
    chk("rd_req2", last_rdata, 8'hA5);
    n0 = glog.size();
    set_req(0, 1'b1, 3'd6, 8'h11);
    set_req(3, 1'b1, 3'd7, 8'h33);
    wait_grants(n0 + 2, 30);
    drain();
    chk("prio_first", glog[n0], 3);
    chk("prio_second", glog[n0+1], 0);

    // Reset during EXEC of a write: dropped, bank cleared, pointer back to 0.
    n0 = glog.size();
    set_req(2, 1'b1, 3'd1, 8'h3C);
    wait_grants(n0 + 1, 20);
    rst = 1'b0;
    set_req(0, 1'b0, 3'd1, 8'h00);
    set_req(3, 1'b0, 3'd3, 8'h00);
    #2;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    n0 = glog.size();
    wait_grants(n0 + 1, 20);
    drain();
    chk("rst_addr1", last_rdata, 8'h00);
    wait_grants(n0 + 2, 20);
    drain();
    chk("rst_next_grant", glog[n0], 0);
    chk("rst_then_grant", glog[n0+1], 3);
    chk("rst_addr3", last_rdata, 8'h00);

    // Round-robin with all requesters continuously valid.
    for (int i = 0; i < N; i++) begin
      keep[i] = 1'b1;
      set_req(i, 1'b1, AW'(i), DW'(i));
    end
    n0 = glog.size();
    wait_grants(n0 + 5, 40);
    req_valid = '0;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", glog[n0+k], k % N);
      if (k > 0) chk("rr_spacing", gcyc[n0+k] - gcyc[n0+k-1], 3);
    end
    for (int i = 0; i < N; i++) begin
      do_op(0, 1'b0, AW'(i), 8'h00);
      chk("rr_read", last_rdata, i);
    end

    // Valid raised during EXEC and withdrawn before IDLE is never taken.
    n0 = glog.size();
    set_req(1, 1'b1, 3'd2, 8'h5A);
    wait_grants(n0 + 1, 20);
    set_req(2, 1'b0, 3'd2, 8'h00);
    tick();
    req_valid[2] = 1'b0;
    tick();
    chk("wd_rsp_data", last_rdata, 8'h5A);
    repeat (3) tick();
    chk("wd_no_grant", glog.size(), n0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shared register-bank controller. Up to NUM_REQ requesters issue single-register read or write commands over a valid/ready handshake. A round-robin scheduler grants one command at a time, executes it against an internal bank of 2^ADDR_W flip-flop registers, and returns a one-cycle response to the granted requester. It sits between the requester ports and the DFF storage, and is the only path that sequences bank accesses.

## Interface
- NUM_REQ, default 4: number of requesters (2..8).
- DATA_W, default 8: register width.
- ADDR_W, default 3: register address width; the bank has 2^ADDR_W entries.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept, one-hot or zero.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- rsp_valid  out  NUM_REQ  one-hot response pulse to the granted requester.
- rsp_rdata  out  DATA_W  response data, valid only while any rsp_valid bit is 1.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid is set, stay in IDLE.
  - Otherwise the arbiter selects winner g: the first requester with valid set, searching from prio_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; this completes the handshake.
  - On that edge: latch g, req_we[g], req_addr[g] and req_wdata[g]; set prio_ptr = (g+1) mod NUM_REQ; go to EXEC.
- EXEC:
  - Write: bank[addr] <= wdata at the end of the cycle.
  - Read: capture bank[addr] into the response register.
  - Next state is RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle.
  - rsp_rdata = the value read, or the written data for writes.
  - Next state is IDLE.
- Handshake rules:
  - A requester holds valid, we, addr and wdata stable until it sees ready.
  - Deasserting valid before ready is allowed; that command is simply never taken.
  - req_ready is 0 in EXEC and RESP.
  - A requester may re-request in the cycle after its rsp_valid.
- Outputs are 0 outside RESP: rsp_valid=0 and rsp_rdata=0.
- Reset, asserted at any time including mid-transaction:
  - FSM goes to IDLE, prio_ptr=0, all bank entries=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - An in-flight command is dropped with no response.

## Timing
- Accept to response: the handshake happens in cycle N, EXEC in N+1, rsp_valid in N+2.
- Maximum throughput is one command per 3 cycles.
- A write is visible to a read accepted in the next IDLE cycle (N+3) or later.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Simultaneous events:
  - Multiple valids in the same IDLE cycle produce exactly one ready.
  - A new valid that rises during EXEC/RESP is considered at the next IDLE.

## Structure
- Shared package `reg_bank_pkg` holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2);
  - the default widths.
- Sub-module `rr_arbiter`, parameterised by NUM_REQ:
  - inputs: request vector, prio_ptr;
  - outputs: one-hot grant and grant index;
  - purely combinational.
- The top level contains the FSM, command latch, prio_ptr register and the bank array.

## Test plan
- Reset: hold rst=0 for 12 ns, then release. All outputs are 0 and busy=0; a read of address 5 by requester 0 returns 0x00.
- Single write/read: requester 1 writes 0xA5 to address 3. Ready is seen in cycle N and rsp_valid[1] with 0xA5 at N+2. A subsequent read of address 3 returns 0xA5.
- Round-robin: requesters 0–3 all valid continuously, each writing its own index to address index. Grants occur in order 0,1,2,3,0, each 3 cycles apart, and reads return 0,1,2,3.
- Priority rotation: after a grant to requester 2, requesters 0 and 3 are valid together. Requester 3 is granted first, then 0.
- Reset mid-operation: assert rst during EXEC of a write of 0x3C to address 1. No rsp_valid follows; after release, address 1 reads 0x00 and the next grant goes to requester 0.
- Valid withdrawal: requester 2 raises valid while requester 1 is in EXEC, then drops it before IDLE. Requester 2 gets no ready and no response, and the FSM stays in IDLE.
